// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - RS-232 frame transmitter: start, LSB-first data, optional parity, 1-2 stop bits
module uart_tx_frame #(
    parameter int DELAY_COUNTS = 11,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CW = $clog2(DELAY_COUNTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic                   stop_q, stop_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic end_bit;
    logic last_data;
    logic last_stop;

    assign end_bit   = (cnt_q == CW'(DELAY_COUNTS - 1));
    assign last_data = (idx_q == 3'(DATA_BITS - 1));
    assign last_stop = (stop_q == 1'(STOP_BITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Parity is captured together with the data so later tx_data changes cannot affect it.
    always_comb begin
        state_d = state_q;
        cnt_d   = end_bit ? '0 : cnt_q + CW'(1);
        idx_d   = idx_q;
        stop_d  = stop_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (tx_start) begin
                    shreg_d = tx_data;
                    par_d   = (^tx_data) ^ (PARITY_ODD != 0);
                    stop_d  = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (end_bit) begin
                    shreg_d = {1'b0, shreg_q[DATA_BITS-1:1]};
                    idx_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (end_bit) begin
                    if (last_data) begin
                        stop_d  = 1'b0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[DATA_BITS-1:1]};
                    end
                end
            end
            S_PARITY: begin
                if (end_bit) begin
                    stop_d  = 1'b0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (end_bit) begin
                    if (last_stop) begin
                        state_d = S_IDLE;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_d   = tx_q;
        busy_d = busy_q;
        done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (tx_start) begin
                    tx_d   = 1'b0;
                    busy_d = 1'b1;
                end
            end
            S_START: begin
                if (end_bit) tx_d = shreg_q[0];
            end
            S_DATA: begin
                if (end_bit) begin
                    if (last_data) tx_d = (PARITY_EN != 0) ? par_q : 1'b1;
                    else           tx_d = shreg_q[0];
                end
            end
            S_PARITY: begin
                if (end_bit) tx_d = 1'b1;
            end
            S_STOP: begin
                if (end_bit && last_stop) begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            default: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - directed vector bench for uart_tx_frame across four configurations
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] start_v = '0;
    logic [7:0] din_v [4];
    wire  [3:0] tx_w;
    wire  [3:0] busy_w;
    wire  [3:0] done_w;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_frame u0 (
        .clk(clk), .rst(rst), .tx_start(start_v[0]), .tx_data(din_v[0]),
        .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0])
    );
    uart_tx_frame #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst(rst), .tx_start(start_v[1]), .tx_data(din_v[1]),
        .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1])
    );
    uart_tx_frame #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
        .clk(clk), .rst(rst), .tx_start(start_v[2]), .tx_data(din_v[2]),
        .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2])
    );
    uart_tx_frame #(.DELAY_COUNTS(2), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .tx_start(start_v[3]), .tx_data(din_v[3]),
        .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3])
    );

    typedef struct {
        int          k;
        logic [7:0]  d;
        logic [11:0] f;
        int          n;
        int          dc;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns at the negedge following the tx_done edge.
    task automatic run_frame(input string tag, input int k, input logic [7:0] d,
                             input logic [11:0] f, input int n, input int dc,
                             input bit hold, input bit disturb);
        int  busy_cnt;
        int  early;
        int  bad;
        busy_cnt = 0;
        early = 0;
        start_v[k] = 1'b1;
        din_v[k] = d;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start_v[k] = 1'b0;
        for (int b = 0; b < n; b++) begin
            bad = 0;
            for (int c = 0; c < dc; c++) begin
                if (tx_w[k] !== f[b]) bad = 1;
                if (busy_w[k] === 1'b1) busy_cnt++;
                if (done_w[k] !== 1'b0) early = 1;
                if (disturb && b == 3 && c == 1) begin
                    din_v[k] = ~d;
                    start_v[k] = 1'b1;
                end
                if (disturb && b == 3 && c == 2) start_v[k] = hold;
                @(negedge clk);
            end
            chk($sformatf("%s_bit%0d", tag, b), 32'(bad), 32'd0);
        end
        chk({tag, "_done"}, 32'(done_w[k]), 32'd1);
        chk({tag, "_busy_fall"}, 32'(busy_w[k]), 32'd0);
        chk({tag, "_tx_idle"}, 32'(tx_w[k]), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(n * dc));
        chk({tag, "_no_early_done"}, 32'(early), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        for (int k = 0; k < 4; k++) din_v[k] = 8'h00;

        vecs[0] = '{0, 8'h55, 12'b00_1_01010101_0, 10, 11};
        vecs[1] = '{0, 8'h01, 12'b00_1_00000001_0, 10, 11};
        vecs[2] = '{1, 8'hA5, 12'b0_1_0_10100101_0, 11, 11};
        vecs[3] = '{1, 8'h07, 12'b0_1_1_00000111_0, 11, 11};
        vecs[4] = '{2, 8'hA5, 12'b0_1_1_10100101_0, 11, 11};
        vecs[5] = '{2, 8'h00, 12'b0_1_1_00000000_0, 11, 11};
        vecs[6] = '{3, 8'h80, 12'b0_11_10000000_0, 11, 2};
        vecs[7] = '{3, 8'h5A, 12'b0_11_01011010_0, 11, 2};

        // Reset with a start pulse that must be ignored
        rst = 1'b1;
        repeat (2) @(negedge clk);
        start_v[0] = 1'b1;
        din_v[0] = 8'h00;
        repeat (2) @(negedge clk);
        start_v[0] = 1'b0;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++)
                if (tx_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || done_w[k] !== 1'b0) seen = 1;
        end
        chk("reset_idle", 32'(seen), 32'd0);
        chk("reset_tx", 32'(tx_w), 32'hF);

        foreach (vecs[i]) begin
            run_frame($sformatf("vec%0d", i), vecs[i].k, vecs[i].d, vecs[i].f,
                      vecs[i].n, vecs[i].dc, 1'b0, 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), 32'(done_w[vecs[i].k]), 32'd0);
        end

        // Mid-frame data change and start pulse are ignored
        run_frame("busy", 0, 8'hC3, 12'b00_1_11000011_0, 10, 11, 1'b0, 1'b1);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) seen = 1;
        end
        chk("busy_no_new_frame", 32'(seen), 32'd0);

        // Back-to-back with tx_start held high
        run_frame("b2b_a", 0, 8'h00, 12'b00_1_00000000_0, 10, 11, 1'b1, 1'b0);
        run_frame("b2b_b", 0, 8'hFF, 12'b00_1_11111111_0, 10, 11, 1'b0, 1'b0);
        @(negedge clk);

        // Reset during data bit 3 of a frame
        start_v[0] = 1'b1;
        din_v[0] = 8'hF0;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4 * 11 + 4) @(negedge clk);
        chk("abort_pre_tx", 32'(tx_w[0]), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("abort_tx_async", 32'(tx_w[0]), 32'd1);
        chk("abort_busy_async", 32'(busy_w[0]), 32'd0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done_w[0] !== 1'b0) seen = 1;
        end
        rst = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1) seen = 1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        run_frame("post_rst", 0, 8'h3C, 12'b00_1_00111100_0, 10, 11, 1'b0, 1'b0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
